sram: RTL and testbench
=======================

# sram

Synchronous single-port 64K x 16 static RAM model with active-low chip, output, write and byte-lane enables, as on a standard asynchronous-SRAM pinout. It is the data memory behind the ASIC's load/store path. Writes commit on the rising clock edge. Reads return registered data one cycle after the address is presented. Separate `din`/`dout` buses are used instead of a tristate bidirectional bus.

## Interface
- `ADDR_WIDTH`, default 16: address bits. Depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, fixed 16: word width, split into two byte lanes.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Clock is `clk`.
- `CE`, input, 1: chip enable, active-low.
- `OE`, input, 1: output enable, active-low.
- `WE`, input, 1: write enable, active-low. 0 = write cycle, 1 = read cycle.
- `LB`, input, 1: lower byte enable (bits 7:0), active-low.
- `UB`, input, 1: upper byte enable (bits 15:8), active-low.
- `addr`, input, 16: word address.
- `din`, input, 16: write data.
- `dout`, output, 16: registered read data.

## Operation
- Storage is an array `mem[0:65535]` of 16-bit words.
- Contents are not initialised and are not cleared by `rst`. Each word is undefined until written.
- Write: at posedge with `CE`=0 and `WE`=0:
  - if `LB`=0, `mem[addr][7:0]` is set to `din[7:0]`;
  - if `UB`=0, `mem[addr][15:8]` is set to `din[15:8]`;
  - a lane whose enable is 1 keeps its old value.
  - `OE` does not matter for writes.
- Read: at posedge with `CE`=0, `WE`=1 and `OE`=0:
  - `dout[7:0]` is set to `LB`=0 ? `mem[addr][7:0]` : 0;
  - `dout[15:8]` is set to `UB`=0 ? `mem[addr][15:8]` : 0.
- Idle or write: at posedge with `CE`=1, or `OE`=1 with `WE`=1, or during a write cycle (`WE`=0), `dout` is set to 0. The output is driven low instead of high-Z.
- Reads and writes never occur in the same cycle, so there is no read/write collision case.
- Addresses wrap naturally. Every 16-bit value is a legal address, with no out-of-range handling.

## Timing
- Reset: `rst`=0 forces `dout`=0 immediately, without waiting for a clock. `dout` stays 0 while `rst` is low.
  - Writes are blocked while `rst`=0.
  - Memory contents survive reset, including a reset asserted in the middle of a sequence.
- Write latency: data written at edge N is readable by a read sampled at edge N+1.
- Read latency: 1 cycle. Address and controls sampled at edge N appear on `dout` after edge N.
  - `dout` is stable until the next edge.
  - If the address is held for several cycles, `dout` stays constant.
- Changing `addr`/`din`/controls between edges has no effect. Only values present at the rising edge matter.
- No handshake or busy signal. A new access may be issued on every cycle.

## Test plan
- Reset and idle:
  - hold `rst`=0 with `CE`=`OE`=`WE`=`LB`=`UB`=1 → `dout`=0;
  - release `rst` → `dout` stays 0.
- Basic write/read:
  - with `CE`=`OE`=`LB`=`UB`=0, write `din`=0 to `addr` 0, 10 to 10, 1234 to 1234, 5678 to 5678, each held for 4 cycles;
  - then read 0, 10, 1234, 5678 → `dout` = 0x0000, 0x000A, 0x04D2, 0x162E, valid one cycle after each address.
- Overwrite:
  - write 0 to `addr` 1234 and 0xFFFF to `addr` 5678;
  - read 1234 → 0x0000, read 5678 → 0xFFFF;
  - write 0 to 5678 and read 5678 → 0x0000.
- Byte lanes:
  - write 0xABCD to `addr` 7 with both lanes enabled, then write 0x1234 with `UB`=1 → reading 7 gives 0xAB34;
  - read 7 with `LB`=1 → 0xAB00.
- Disable gating:
  - during a read of a written location, raise `OE` → `dout`=0 on the next edge;
  - raise `CE` during a write → memory unchanged, confirmed by read-back.
- Reset mid-operation:
  - after writing 0x5A5A to `addr` 100, pulse `rst` low for a fraction of a cycle → `dout`=0 asynchronously;
  - a later read of 100 → 0x5A5A.

Source files
------------

// File: rtl/sram.sv
// sram: synchronous single-port RAM with active-low chip, output, write and
// byte-lane enables. Each byte lane is its own storage slice with its own
// registered output. Contents are never cleared; only dout resets.

module sram_lane #(
    parameter int ADDR_WIDTH = 16,
    parameter int LANE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LANE_W-1:0]     din,
    output logic [LANE_W-1:0]     dout
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [LANE_W-1:0] mem [0:DEPTH-1];

    // Storage commit; held off while reset is low, but contents are never cleared
    always_ff @(posedge clk) begin
        if (rst && wr)
            mem[addr] <= din;
    end

    // Registered read port; drives zero when not reading or lane disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout <= '0;
        else if (rd)
            dout <= mem[addr];
        else
            dout <= '0;
    end
endmodule

module sram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CE,
    input  logic                  OE,
    input  logic                  WE,
    input  logic                  LB,
    input  logic                  UB,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = DATA_WIDTH / LANE_W;

    // Decoded access for the current cycle
    typedef struct packed {
        logic wr;
        logic rd;
    } req_t;

    req_t                                req;
    logic [NUM_LANES-1:0]                lane_en_n;
    logic [NUM_LANES-1:0][LANE_W-1:0]    din_lanes;
    logic [NUM_LANES-1:0][LANE_W-1:0]    dout_lanes;

    // Write ignores OE; a read needs chip and output enabled with WE high
    always_comb begin
        req    = '0;
        req.wr = !CE && !WE;
        req.rd = !CE &&  WE && !OE;
    end

    assign lane_en_n = {UB, LB};
    assign din_lanes = din;
    assign dout      = dout_lanes;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            sram_lane #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .LANE_W     (LANE_W)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .wr   (req.wr && !lane_en_n[i]),
                .rd   (req.rd && !lane_en_n[i]),
                .addr (addr),
                .din  (din_lanes[i]),
                .dout (dout_lanes[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_sram.sv
// tb_sram: directed checks of the sram model. Inputs change on the falling
// edge; dout is sampled on the falling edge after the capturing rising edge.

module tb_sram;
    logic        clk;
    logic        rst;
    logic        CE, OE, WE, LB, UB;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] dout;

    int pass_cnt = 0;
    int total    = 0;

    sram #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .CE   (CE),
        .OE   (OE),
        .WE   (WE),
        .LB   (LB),
        .UB   (UB),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_write(input logic [15:0] a, input logic [15:0] d,
                               input logic lb, input logic ub);
        CE = 0; WE = 0; OE = 0; LB = lb; UB = ub; addr = a; din = d;
        @(negedge clk);
    endtask

    task automatic drive_read(input logic [15:0] a, input logic lb, input logic ub);
        CE = 0; WE = 1; OE = 0; LB = lb; UB = ub; addr = a; din = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0;
        #2;
        total++;
        if (dout !== 16'h0000) $display("FAIL reset_hold dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        total++;
        if (dout !== 16'h0000) $display("FAIL reset_release dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [15:0] addrs [4];
        logic [15:0] exps  [4];
        addrs = '{16'd0, 16'd10, 16'd1234, 16'd5678};
        exps  = '{16'h0000, 16'h000A, 16'h04D2, 16'h162E};
        for (int i = 0; i < 4; i++) begin
            repeat (4) drive_write(addrs[i], addrs[i], 0, 0);
            total++;
            if (dout !== 16'h0000) $display("FAIL write_dout_zero addr=%0d dout=%h expected=%h", addrs[i], dout, 16'h0000);
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            drive_read(addrs[i], 0, 0);
            total++;
            if (dout !== exps[i]) $display("FAIL basic_read addr=%0d dout=%h expected=%h", addrs[i], dout, exps[i]);
            else pass_cnt++;
        end
        // Holding the address keeps dout constant
        repeat (2) drive_read(16'd5678, 0, 0);
        total++;
        if (dout !== 16'h162E) $display("FAIL read_hold dout=%h expected=%h", dout, 16'h162E);
        else pass_cnt++;
    endtask

    task automatic test_overwrite();
        drive_write(16'd1234, 16'h0000, 0, 0);
        drive_write(16'd5678, 16'hFFFF, 0, 0);
        drive_read(16'd1234, 0, 0);
        total++;
        if (dout !== 16'h0000) $display("FAIL overwrite_1234 dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
        drive_read(16'd5678, 0, 0);
        total++;
        if (dout !== 16'hFFFF) $display("FAIL overwrite_5678 dout=%h expected=%h", dout, 16'hFFFF);
        else pass_cnt++;
        drive_write(16'd5678, 16'h0000, 0, 0);
        drive_read(16'd5678, 0, 0);
        total++;
        if (dout !== 16'h0000) $display("FAIL overwrite_5678_zero dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
    endtask

    task automatic test_byte_lanes();
        drive_write(16'd7, 16'hABCD, 0, 0);
        drive_write(16'd7, 16'h1234, 0, 1);
        drive_read(16'd7, 0, 0);
        total++;
        if (dout !== 16'hAB34) $display("FAIL lane_low_write dout=%h expected=%h", dout, 16'hAB34);
        else pass_cnt++;
        drive_read(16'd7, 1, 0);
        total++;
        if (dout !== 16'hAB00) $display("FAIL lane_read_upper dout=%h expected=%h", dout, 16'hAB00);
        else pass_cnt++;
        drive_read(16'd7, 0, 1);
        total++;
        if (dout !== 16'h0034) $display("FAIL lane_read_lower dout=%h expected=%h", dout, 16'h0034);
        else pass_cnt++;
        // Upper-only write on a different word
        drive_write(16'd8, 16'h0000, 0, 0);
        drive_write(16'd8, 16'hC3A5, 1, 0);
        drive_read(16'd8, 0, 0);
        total++;
        if (dout !== 16'hC300) $display("FAIL lane_high_write dout=%h expected=%h", dout, 16'hC300);
        else pass_cnt++;
    endtask

    task automatic test_disable();
        drive_read(16'd7, 0, 0);
        total++;
        if (dout !== 16'hAB34) $display("FAIL gate_pre_read dout=%h expected=%h", dout, 16'hAB34);
        else pass_cnt++;
        OE = 1;
        @(negedge clk);
        total++;
        if (dout !== 16'h0000) $display("FAIL gate_oe dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
        // Write with CE high must not land
        CE = 1; WE = 0; OE = 0; LB = 0; UB = 0; addr = 16'd7; din = 16'hFFFF;
        @(negedge clk);
        total++;
        if (dout !== 16'h0000) $display("FAIL gate_ce_dout dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
        drive_read(16'd7, 0, 0);
        total++;
        if (dout !== 16'hAB34) $display("FAIL gate_ce_write dout=%h expected=%h", dout, 16'hAB34);
        else pass_cnt++;
        // CE high on a read also returns zero
        CE = 1; WE = 1; OE = 0;
        @(negedge clk);
        total++;
        if (dout !== 16'h0000) $display("FAIL gate_ce_read dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive_write(16'd100, 16'h5A5A, 0, 0);
        drive_read(16'd100, 0, 0);
        total++;
        if (dout !== 16'h5A5A) $display("FAIL rst_mid_pre dout=%h expected=%h", dout, 16'h5A5A);
        else pass_cnt++;
        #1 rst = 0;
        #1;
        total++;
        if (dout !== 16'h0000) $display("FAIL rst_mid_async dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
        #1 rst = 1;
        @(negedge clk);
        drive_read(16'd100, 0, 0);
        total++;
        if (dout !== 16'h5A5A) $display("FAIL rst_mid_survive dout=%h expected=%h", dout, 16'h5A5A);
        else pass_cnt++;
        // Write attempted across a rising edge while reset is low is blocked
        rst = 0;
        CE = 0; WE = 0; OE = 0; LB = 0; UB = 0; addr = 16'd100; din = 16'h0000;
        @(negedge clk);
        total++;
        if (dout !== 16'h0000) $display("FAIL rst_hold_dout dout=%h expected=%h", dout, 16'h0000);
        else pass_cnt++;
        rst = 1;
        drive_read(16'd100, 0, 0);
        total++;
        if (dout !== 16'h5A5A) $display("FAIL rst_blocks_write dout=%h expected=%h", dout, 16'h5A5A);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] wdata [4];
        wdata = '{16'h1111, 16'h2222, 16'hBEEF, 16'h0F0F};
        for (int i = 0; i < 4; i++) drive_write(16'hFFFC + 16'(i), wdata[i], 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive_read(16'hFFFC + 16'(i), 0, 0);
            total++;
            if (dout !== wdata[i]) $display("FAIL b2b_read addr=%h dout=%h expected=%h", 16'hFFFC + 16'(i), dout, wdata[i]);
            else pass_cnt++;
        end
        // Write immediately followed by a read of the same word
        drive_write(16'd300, 16'h7E81, 0, 0);
        drive_read(16'd300, 0, 0);
        total++;
        if (dout !== 16'h7E81) $display("FAIL b2b_wr_rd dout=%h expected=%h", dout, 16'h7E81);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1; CE = 1; OE = 1; WE = 1; LB = 1; UB = 1;
        addr = '0; din = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overwrite();
        test_byte_lanes();
        test_disable();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
